mips_decode_exec: RTL and testbench
===================================

// Module: mips_decode_exec
// PURPOSE
//   Single-issue MIPS decode/execute slice: main control decoder, ALU control decoder and 32-bit ALU.
//   Takes a fetched instruction plus register-file operands and produces pipeline control bits,
//   the ALU result and the zero flag. All outputs are registered.
//   Sits at the ID/EX boundary of the five-stage CPU; its outputs feed the EX/MEM pipeline register.
// PARAMETERS
//   W  32  datapath width; only W=32 is supported. The sign-extension rule below assumes 32.
// PORTS
//   clk         in   1   rising-edge clock
//   rst_n       in   1   reset, asynchronous assert, active-low
//   in_valid    in   1   instr/operands valid this cycle; 0 inserts a bubble
//   instr       in   32  instruction word: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0] imm[15:0]
//   rs_data     in   32  value of $rs, ALU operand A
//   rt_data     in   32  value of $rt, ALU operand B when alusrc=0
//   out_valid   out  1   registered copy of in_valid
//   regdst      out  1   1: write register is rd; 0: write register is rt
//   branch      out  1   instruction is beq
//   memread     out  1   instruction is lw
//   memwrite    out  1   instruction is sw
//   memtoreg    out  1   1: writeback data comes from memory
//   regwrite    out  1   instruction writes the register file
//   alusrc      out  1   1: operand B is the sign-extended imm
//   aluop       out  2   00 add, 01 sub, 10 R-type (funct), 11 reserved
//   aluctl      out  4   decoded ALU operation
//   alu_result  out  32  ALU output
//   zero        out  1   alu_result == 0
// BEHAVIOUR
//   - Reset: while rst_n=0, every output is 0. Reset is asynchronous, so outputs clear immediately
//     without waiting for a clock edge. Release takes effect at the next clk rise.
//   - Latency: 1 cycle. Decode and ALU are combinational; every output is captured at posedge clk.
//   - in_valid=0: at the next edge out_valid=0 and all control outputs, aluctl, alu_result and zero are 0.
//   - Main decode, by opcode (regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop):
//       0x00 R-type  1,0,0,1,0,0,0,10
//       0x23 lw      0,1,1,1,1,0,0,00
//       0x2B sw      0,1,0,0,0,1,0,00
//       0x04 beq     0,0,0,0,0,0,1,01
//       0x08 addi    0,1,0,1,0,0,0,00
//       any other opcode: all control bits 0, aluop=00. This acts as a NOP; no error flag is raised.
//   - ALU control:
//       aluop 00 -> 0010; aluop 01 -> 0110; aluop 11 -> 1111.
//       aluop 10 selects by funct: 0x20 add=0010, 0x22 sub=0110, 0x24 and=0000, 0x25 or=0001,
//       0x2A slt=0111, 0x27 nor=1100; any other funct -> 1111.
//   - Operand B = alusrc ? {{16{imm[15]}},imm} : rt_data.
//   - ALU, by aluctl:
//       0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 1100 ~(A|B); 0111 ($signed(A)<$signed(B)) ? 1 : 0.
//       1111 and any other code -> 0.
//       Add and sub wrap modulo 2^32; no overflow trap or flag.
//   - zero = (alu_result == 0). It is computed on the unregistered result and registered alongside it.
//   - shamt is ignored; shifts are not supported.
//   - beq computes rs_data - rt_data, so zero=1 means the branch is taken. The branch target is computed outside this block.
//   - Inputs are sampled only at clock edges. No handshake and no backpressure: a new instruction is accepted every cycle.
// TESTING
//   - Reset: drive rst_n=0 mid-stream -> all outputs 0 immediately without a clock edge; they stay 0 until
//     the first edge after release.
//   - R-type add: instr=0x00221820, rs=5, rt=7, in_valid=1 -> next cycle alu_result=12, aluctl=0010,
//     regdst=1, regwrite=1, aluop=10, zero=0, out_valid=1.
//   - slt signed: funct=0x2A, rs=0xFFFFFFFF, rt=1 -> alu_result=1.
//     Then rs=1, rt=0xFFFFFFFF -> alu_result=0, zero=1.
//   - lw/sw: instr=0x8C22FFFC (lw), rs=0x100 -> alu_result=0xFC, alusrc=1, memread=1, memtoreg=1, regwrite=1.
//     Same imm with opcode 0x2B -> memwrite=1, regwrite=0.
//   - beq: instr=0x10220003, rs=rt=9 -> branch=1, aluctl=0110, zero=1. With rt=8 -> zero=0.
//   - Bubble/illegal: in_valid=0 -> every output 0 next cycle. Opcode 0x3F -> all control bits 0.
//     R-type funct 0x3F -> aluctl=1111, alu_result=0, zero=1.

Source files
------------

// File: rtl/mips_decode_exec.sv
// MIPS ID/EX slice: main control decoder, ALU control decoder and 32-bit ALU.
// Every output is registered and cleared by an asynchronous active-low reset.
module mips_decode_exec #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [31:0]  instr,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    output logic         out_valid,
    output logic         regdst,
    output logic         branch,
    output logic         memread,
    output logic         memwrite,
    output logic         memtoreg,
    output logic         regwrite,
    output logic         alusrc,
    output logic [1:0]   aluop,
    output logic [3:0]   aluctl,
    output logic [W-1:0] alu_result,
    output logic         zero
);

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned CTL_W  = 4;
    localparam int unsigned AOP_W  = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

    localparam logic [FN_W-1:0] FN_ADD = 6'h20;
    localparam logic [FN_W-1:0] FN_SUB = 6'h22;
    localparam logic [FN_W-1:0] FN_AND = 6'h24;
    localparam logic [FN_W-1:0] FN_OR  = 6'h25;
    localparam logic [FN_W-1:0] FN_SLT = 6'h2A;
    localparam logic [FN_W-1:0] FN_NOR = 6'h27;

    localparam logic [CTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CTL_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [CTL_W-1:0] ALU_NOP = 4'b1111;

    logic [OP_W-1:0]  op;
    logic [FN_W-1:0]  funct;
    logic [IMM_W-1:0] imm;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    logic             regdst_c, branch_c, memread_c, memwrite_c;
    logic             memtoreg_c, regwrite_c, alusrc_c;
    logic [AOP_W-1:0] aluop_c;
    logic [CTL_W-1:0] aluctl_c;
    logic [W-1:0]     opb_c;
    logic [W-1:0]     result_c;
    logic             zero_c;

    // Main control decode; unknown opcodes fall through as a NOP
    always_comb begin
        regdst_c   = 1'b0;
        alusrc_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        branch_c   = 1'b0;
        aluop_c    = 2'b00;
        case (op)
            OP_RTYPE: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                aluop_c    = 2'b10;
            end
            OP_LW: begin
                alusrc_c   = 1'b1;
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                memread_c  = 1'b1;
            end
            OP_SW: begin
                alusrc_c   = 1'b1;
                memwrite_c = 1'b1;
            end
            OP_BEQ: begin
                branch_c   = 1'b1;
                aluop_c    = 2'b01;
            end
            OP_ADDI: begin
                alusrc_c   = 1'b1;
                regwrite_c = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU control decode
    always_comb begin
        aluctl_c = ALU_NOP;
        case (aluop_c)
            2'b00: aluctl_c = ALU_ADD;
            2'b01: aluctl_c = ALU_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  aluctl_c = ALU_ADD;
                    FN_SUB:  aluctl_c = ALU_SUB;
                    FN_AND:  aluctl_c = ALU_AND;
                    FN_OR:   aluctl_c = ALU_OR;
                    FN_SLT:  aluctl_c = ALU_SLT;
                    FN_NOR:  aluctl_c = ALU_NOR;
                    default: aluctl_c = ALU_NOP;
                endcase
            end
            default: aluctl_c = ALU_NOP;
        endcase
    end

    assign opb_c = alusrc_c ? {{(W-IMM_W){imm[IMM_W-1]}}, imm} : rt_data;

    // ALU datapath; add/sub wrap with no overflow indication
    always_comb begin
        result_c = '0;
        case (aluctl_c)
            ALU_AND: result_c = rs_data & opb_c;
            ALU_OR:  result_c = rs_data | opb_c;
            ALU_ADD: result_c = rs_data + opb_c;
            ALU_SUB: result_c = rs_data - opb_c;
            ALU_NOR: result_c = ~(rs_data | opb_c);
            ALU_SLT: result_c = ($signed(rs_data) < $signed(opb_c)) ? W'(1) : '0;
            default: result_c = '0;
        endcase
    end

    assign zero_c = (result_c == '0);

    // Output register; a bubble clears every output including zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            regdst     <= 1'b0;
            branch     <= 1'b0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            memtoreg   <= 1'b0;
            regwrite   <= 1'b0;
            alusrc     <= 1'b0;
            aluop      <= '0;
            aluctl     <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
        end else if (!in_valid) begin
            out_valid  <= 1'b0;
            regdst     <= 1'b0;
            branch     <= 1'b0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            memtoreg   <= 1'b0;
            regwrite   <= 1'b0;
            alusrc     <= 1'b0;
            aluop      <= '0;
            aluctl     <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
        end else begin
            out_valid  <= 1'b1;
            regdst     <= regdst_c;
            branch     <= branch_c;
            memread    <= memread_c;
            memwrite   <= memwrite_c;
            memtoreg   <= memtoreg_c;
            regwrite   <= regwrite_c;
            alusrc     <= alusrc_c;
            aluop      <= aluop_c;
            aluctl     <= aluctl_c;
            alu_result <= result_c;
            zero       <= zero_c;
        end
    end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed bench for mips_decode_exec: hand-computed vectors checked with immediate assertions.
module tb_mips_decode_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid, regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] alu_result;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    mips_decode_exec #(.W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .out_valid  (out_valid),
        .regdst     (regdst),
        .branch     (branch),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrc     (alusrc),
        .aluop      (aluop),
        .aluctl     (aluctl),
        .alu_result (alu_result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // {out_valid, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}
    function automatic logic [9:0] ctrl_vec();
        return {out_valid, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [9:0] e_ctrl, input logic [3:0] e_aluctl,
                             input logic [31:0] e_res, input logic e_zero);
        check({tag, ".ctrl"},   32'(ctrl_vec()), 32'(e_ctrl));
        check({tag, ".aluctl"}, 32'(aluctl),     32'(e_aluctl));
        check({tag, ".result"}, alu_result,      e_res);
        check({tag, ".zero"},   32'(zero),       32'(e_zero));
    endtask

    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        instr    = i;
        rs_data  = a;
        rt_data  = b;
        @(posedge clk);
        #1;
    endtask

    localparam logic [9:0] C_R    = 10'b1_1_0_0_1_0_0_0_10;
    localparam logic [9:0] C_LW   = 10'b1_0_1_1_1_1_0_0_00;
    localparam logic [9:0] C_SW   = 10'b1_0_1_0_0_0_1_0_00;
    localparam logic [9:0] C_BEQ  = 10'b1_0_0_0_0_0_0_1_01;
    localparam logic [9:0] C_ADDI = 10'b1_0_1_0_1_0_0_0_00;
    localparam logic [9:0] C_NOP  = 10'b1_0_0_0_0_0_0_0_00;
    localparam logic [9:0] C_OFF  = 10'b0;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        rs_data  = '0;
        rt_data  = '0;
        #1;
        check_all("reset_init", C_OFF, 4'b0000, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        step(1'b1, 32'h00221820, 32'd5, 32'd7);
        check_all("add", C_R, 4'b0010, 32'd12, 1'b0);
        step(1'b1, 32'h00221822, 32'd5, 32'd7);
        check_all("sub", C_R, 4'b0110, 32'hFFFFFFFE, 1'b0);
        step(1'b1, 32'h00221824, 32'h0000F0F0, 32'h0000FF00);
        check_all("and", C_R, 4'b0000, 32'h0000F000, 1'b0);
        step(1'b1, 32'h00221825, 32'h0000F0F0, 32'h0000FF00);
        check_all("or", C_R, 4'b0001, 32'h0000FFF0, 1'b0);
        step(1'b1, 32'h00221827, 32'h0000F0F0, 32'h0000FF00);
        check_all("nor", C_R, 4'b1100, 32'hFFFF000F, 1'b0);
        step(1'b1, 32'h0022182A, 32'hFFFFFFFF, 32'd1);
        check_all("slt_neg_lt", C_R, 4'b0111, 32'd1, 1'b0);
        step(1'b1, 32'h0022182A, 32'd1, 32'hFFFFFFFF);
        check_all("slt_pos_ge", C_R, 4'b0111, 32'd0, 1'b1);
        step(1'b1, 32'h00221820, 32'hFFFFFFFF, 32'd1);
        check_all("add_wrap", C_R, 4'b0010, 32'd0, 1'b1);

        step(1'b1, 32'h8C22FFFC, 32'h00000100, 32'h12345678);
        check_all("lw", C_LW, 4'b0010, 32'h000000FC, 1'b0);
        step(1'b1, 32'hAC22FFFC, 32'h00000100, 32'h12345678);
        check_all("sw", C_SW, 4'b0010, 32'h000000FC, 1'b0);
        step(1'b1, 32'h20228000, 32'h00000010, 32'h0);
        check_all("addi_sext", C_ADDI, 4'b0010, 32'hFFFF8010, 1'b0);

        step(1'b1, 32'h10220003, 32'd9, 32'd9);
        check_all("beq_taken", C_BEQ, 4'b0110, 32'd0, 1'b1);
        step(1'b1, 32'h10220003, 32'd9, 32'd8);
        check_all("beq_not", C_BEQ, 4'b0110, 32'd1, 1'b0);

        step(1'b0, 32'h00221820, 32'd5, 32'd7);
        check_all("bubble", C_OFF, 4'b0000, 32'd0, 1'b0);
        step(1'b1, 32'hFC221820, 32'd5, 32'd7);
        check_all("illegal_op", C_NOP, 4'b0010, 32'd12, 1'b0);
        step(1'b1, 32'h0022183F, 32'd5, 32'd7);
        check_all("illegal_funct", C_R, 4'b1111, 32'd0, 1'b1);

        // Mid-stream asynchronous reset, asserted and released away from clock edges
        step(1'b1, 32'h00221820, 32'd5, 32'd7);
        check_all("pre_reset", C_R, 4'b0010, 32'd12, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", C_OFF, 4'b0000, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_held", C_OFF, 4'b0000, 32'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        check_all("reset_released", C_OFF, 4'b0000, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        check_all("after_release", C_R, 4'b0010, 32'd12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
